// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Segment codes are gfedcba (bit 6 = g), active-low.
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with per-frame input shadowing,
// leading-zero suppression and slot-phase PWM brightness.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_BITS   = 18,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] x,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              a_to_g,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("seg7_scan_ctrl: NUM_DIGITS out of range");
    end
    if (SLOT_BITS < BRIGHT_BITS) begin : g_bad_bright
        $error("seg7_scan_ctrl: SLOT_BITS must be >= BRIGHT_BITS");
    end

    logic [SLOT_BITS-1:0]    slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] x_s_q;
    logic [NUM_DIGITS-1:0]   dp_s_q;
    logic [NUM_DIGITS-1:0]   blank_s_q;
    logic                    lz_s_q;
    logic                    loaded_q;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    dp_q, dp_d;
    logic                    tick_q;

    logic                    slot_wrap;
    logic                    frame_end;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   supp;
    logic                    seen_nz;
    logic [BRIGHT_BITS-1:0]  phase;
    logic                    pwm_on;
    logic                    lit;
    logic [6:0]              seg_dec;

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib[gi] = x_s_q[4*gi +: 4];
    end

    assign slot_wrap = &slot_q;
    assign frame_end = slot_wrap && (idx_q == LAST_IDX);

    always_comb begin
        slot_d = slot_q + SLOT_BITS'(1);
        idx_d  = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan from the top digit down: a digit is suppressed while every
    // digit at or above it is zero. Digit 0 is never suppressed.
    always_comb begin
        supp    = '0;
        seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen_nz = seen_nz | (x_s_q[4*i +: 4] != 4'h0);
            supp[i] = lz_s_q & ~seen_nz;
        end
    end

    assign phase  = slot_q[SLOT_BITS-1 -: BRIGHT_BITS];
    assign pwm_on = (&brightness) || (phase < brightness);
    assign lit    = loaded_q && !blank_s_q[idx_q] && !supp[idx_q] && pwm_on;

    seg7_hex_decode u_dec (
        .nibble_i (nib[idx_q]),
        .seg_o    (seg_dec)
    );

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        dp_d  = 1'b1;
        if (lit) begin
            seg_d = seg_dec;
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            dp_d  = ~dp_s_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            slot_q    <= '0;
            idx_q     <= '0;
            x_s_q     <= '0;
            dp_s_q    <= '0;
            blank_s_q <= '0;
            lz_s_q    <= 1'b0;
            loaded_q  <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= '1;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
            tick_q <= frame_end;
            // The next frame runs entirely from this snapshot.
            if (frame_end) begin
                x_s_q     <= x;
                dp_s_q    <= dp_in;
                blank_s_q <= blank;
                lz_s_q    <= lz_en;
                loaded_q  <= 1'b1;
            end
        end
    end

    assign a_to_g     = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule
